regfile_writeback_ctrl: RTL and testbench

- Writer-side controller for the 3-entry register file (X=0, Y=1, ACCUMULATOR=2). It is the only source of write_enable, write_destination and write_data.
- Buffers completed results from execute units in a small FIFO and retires one per cycle as a registered write.
- Keeps a per-register pending-write scoreboard, so decode can detect read-after-write hazards on read_sources_1/2 before issuing.

---
 rtl/regfile_writeback_ctrl.sv | 171 +++++++++++++++++
 tb/tb_regfile_writeback_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_ctrl.sv
// Write-back controller for the 3-entry register file: buffers execute results
// in a small FIFO, retires one per cycle, and tracks pending writes per register.
module regfile_writeback_ctrl #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rsv_valid,
  input  logic [1:0]              rsv_dest,
  output logic                    rsv_ok,
  input  logic                    res_valid,
  output logic                    res_ready,
  input  logic [1:0]              res_dest,
  input  logic [W-1:0]            res_data,
  input  logic                    drain_en,
  input  logic [1:0]              read_sources_1,
  input  logic [1:0]              read_sources_2,
  input  logic                    src1_use,
  input  logic                    src2_use,
  output logic                    hazard,
  output logic                    write_enable,
  output logic [1:0]              write_destination,
  output logic [W-1:0]            write_data,
  output logic [2:0]              busy,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [AW:0] FULL      = (AW+1)'(DEPTH);
  localparam logic [1:0]  DEST_NONE = 2'd3;

  logic [W-1:0]  data_q [DEPTH];
  logic [1:0]    dest_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [2:0]    inc_vec, dec_vec;

  logic          we_q, we_d;
  logic [1:0]    wdst_q, wdst_d;
  logic [W-1:0]  wdata_q, wdata_d;

  logic          push, pop;
  logic [1:0]    head_dest;
  logic [W-1:0]  head_data;

  assign head_dest = dest_q[head_q];
  assign head_data = data_q[head_q];

  // No pass-through when full: readiness depends only on stored occupancy.
  assign res_ready  = (count_q != FULL);
  assign push       = res_valid && res_ready;
  assign pop        = drain_en && (count_q != '0);
  assign fifo_count = count_q;

  assign write_enable      = we_q;
  assign write_destination = wdst_q;
  assign write_data        = wdata_q;

  always_comb begin
    rsv_ok = 1'b1;
    for (int unsigned r = 0; r < 3; r++) begin
      if ((rsv_dest == 2'(r)) && (cnt_q[r] == '1)) begin
        rsv_ok = 1'b0;
      end
    end
  end

  // A register stays busy while its retiring write sits on the output port.
  always_comb begin
    busy = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      busy[r] = (cnt_q[r] != '0) || (we_q && (wdst_q == 2'(r)));
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int unsigned r = 0; r < 3; r++) begin
      if (busy[r] && ((src1_use && (read_sources_1 == 2'(r))) ||
                      (src2_use && (read_sources_2 == 2'(r))))) begin
        hazard = 1'b1;
      end
    end
  end

  // Decrement is suppressed at zero so an unreserved result cannot underflow.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      inc_vec[r] = rsv_valid && rsv_ok && (rsv_dest == 2'(r));
      dec_vec[r] = pop && (head_dest == 2'(r)) && (cnt_q[r] != '0);
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      tail_d = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    we_d    = pop && (head_dest != DEST_NONE);
    wdst_d  = wdst_q;
    wdata_d = wdata_q;
    if (we_d) begin
      wdst_d  = head_dest;
      wdata_d = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[tail_q] <= res_data;
      dest_q[tail_q] <= res_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      wdst_q  <= '0;
      wdata_q <= '0;
      for (int unsigned r = 0; r < 3; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we_q    <= we_d;
      wdst_q  <= wdst_d;
      wdata_q <= wdata_d;
      for (int unsigned r = 0; r < 3; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Scoreboard bench for regfile_writeback_ctrl: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_regfile_writeback_ctrl;
  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int SAT   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          rsv_valid;
  logic [1:0]    rsv_dest;
  logic          rsv_ok;
  logic          res_valid;
  logic          res_ready;
  logic [1:0]    res_dest;
  logic [W-1:0]  res_data;
  logic          drain_en;
  logic [1:0]    read_sources_1, read_sources_2;
  logic          src1_use, src2_use;
  logic          hazard;
  logic          write_enable;
  logic [1:0]    write_destination;
  logic [W-1:0]  write_data;
  logic [2:0]    busy;
  logic [$clog2(DEPTH):0] fifo_count;

  regfile_writeback_ctrl #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .rsv_valid(rsv_valid), .rsv_dest(rsv_dest), .rsv_ok(rsv_ok),
    .res_valid(res_valid), .res_ready(res_ready), .res_dest(res_dest), .res_data(res_data),
    .drain_en(drain_en),
    .read_sources_1(read_sources_1), .read_sources_2(read_sources_2),
    .src1_use(src1_use), .src2_use(src2_use), .hazard(hazard),
    .write_enable(write_enable), .write_destination(write_destination), .write_data(write_data),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {int dest; int data;} res_t;

  res_t fifo_m[$];
  res_t exp_q[$];
  int   cnt_m[3];
  int   inflight = -1;
  bit   model_ok = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; rsv_valid = 1'b0; rsv_dest = 2'd0;
    res_valid = 1'b0; res_dest = 2'd0; res_data = '0; drain_en = 1'b0;
    read_sources_1 = 2'd0; read_sources_2 = 2'd0; src1_use = 1'b0; src2_use = 1'b0;
  endtask

  // Check combinational outputs against the model, then advance the model across the edge.
  task automatic cycle();
    bit   bm [3];
    int   bvec;
    bit   haz, inc, push, pop;
    res_t h;
    #2;
    if (model_ok) begin
      bvec = 0;
      for (int r = 0; r < 3; r++) begin
        bm[r] = (cnt_m[r] > 0) || (inflight == r);
        if (bm[r]) bvec |= (1 << r);
      end
      haz = (src1_use && read_sources_1 != 2'd3 && bm[read_sources_1]) ||
            (src2_use && read_sources_2 != 2'd3 && bm[read_sources_2]);
      chk("res_ready", int'(res_ready), int'(fifo_m.size() < DEPTH));
      chk("fifo_count", int'(fifo_count), fifo_m.size());
      chk("busy", int'(busy), bvec);
      chk("rsv_ok", int'(rsv_ok), int'(rsv_dest == 2'd3 || cnt_m[rsv_dest] < SAT));
      chk("hazard", int'(hazard), int'(haz));
    end
    if (rst) begin
      fifo_m.delete();
      for (int r = 0; r < 3; r++) cnt_m[r] = 0;
      inflight = -1;
      model_ok = 1'b1;
    end else if (model_ok) begin
      inc  = rsv_valid && rsv_dest != 2'd3 && cnt_m[rsv_dest] < SAT;
      push = res_valid && fifo_m.size() < DEPTH;
      pop  = drain_en && fifo_m.size() > 0;
      inflight = -1;
      if (pop) begin
        h = fifo_m.pop_front();
        if (h.dest != 3) begin
          exp_q.push_back(h);
          inflight = h.dest;
          if (cnt_m[h.dest] > 0) cnt_m[h.dest]--;
        end
      end
      if (inc) cnt_m[rsv_dest]++;
      if (push) begin
        h.dest = int'(res_dest);
        h.data = int'(res_data);
        fifo_m.push_back(h);
      end
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor: every write the DUT presents must match the oldest expected retirement.
  initial begin
    res_t h;
    forever begin
      @(posedge clk);
      #1;
      if (model_ok) begin
        if (write_enable === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got dest %0d data %0h expected no write", write_destination, write_data);
          end else begin
            h = exp_q.pop_front();
            chk("wr_dest", int'(write_destination), h.dest);
            chk("wr_data", int'(write_data), h.data);
          end
        end else if (exp_q.size() != 0) begin
          h = exp_q.pop_front();
          checks++; errors++;
          $display("FAIL missing_write: got write_enable %b expected write dest %0d data %0h", write_enable, h.dest, h.data);
        end
      end
    end
  end

  initial begin
    idle_inputs();
    @(posedge clk); #2;
    rst = 1'b1; cycle(); cycle();
    rst = 1'b0;
    chk("reset_we", int'(write_enable), 0);
    chk("reset_wdst", int'(write_destination), 0);
    chk("reset_wdata", int'(write_data), 0);
    cycle();

    // Single op on ACCUMULATOR with hazard visible until commit.
    rsv_valid = 1'b1; rsv_dest = 2'd2; cycle();
    rsv_valid = 1'b0; read_sources_1 = 2'd2; src1_use = 1'b1;
    res_valid = 1'b1; res_dest = 2'd2; res_data = 16'h0008; drain_en = 1'b1; cycle();
    res_valid = 1'b0;
    repeat (4) cycle();

    // Backpressure: fill with drain off, refused fifth push, then drain in order.
    drain_en = 1'b0; src1_use = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rsv_valid = (i < 4); rsv_dest = (i == 3) ? 2'd0 : 2'(i);
      res_valid = 1'b1; res_dest = (i == 3) ? 2'd0 : 2'(i); res_data = 16'(i + 1);
      cycle();
    end
    rsv_valid = 1'b0; res_valid = 1'b0; drain_en = 1'b1;
    repeat (5) cycle();

    // Push offered while full and draining.
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rsv_valid = 1'b1; rsv_dest = 2'd2; res_valid = 1'b1; res_dest = 2'd2; res_data = 16'h0100 + 16'(i);
      cycle();
    end
    rsv_valid = 1'b0; drain_en = 1'b1; res_data = 16'h0200;
    repeat (3) cycle();
    res_valid = 1'b0; repeat (5) cycle();

    // Same-edge reserve and retire on Y.
    rsv_valid = 1'b1; rsv_dest = 2'd1; cycle();
    rsv_valid = 1'b0; res_valid = 1'b1; res_dest = 2'd1; res_data = 16'h1111; cycle();
    res_valid = 1'b0; rsv_valid = 1'b1; read_sources_2 = 2'd1; src2_use = 1'b1; cycle();
    rsv_valid = 1'b0; cycle();
    res_valid = 1'b1; res_data = 16'h2222; cycle();
    res_valid = 1'b0; repeat (4) cycle();
    src2_use = 1'b0;

    // Invalid destination result.
    res_valid = 1'b1; res_dest = 2'd3; res_data = 16'hFFFF; cycle();
    res_valid = 1'b0; repeat (3) cycle();

    // Saturate X, then one more attempt.
    rsv_dest = 2'd0; rsv_valid = 1'b1;
    repeat (SAT + 1) cycle();
    rsv_valid = 1'b0; read_sources_1 = 2'd0; src1_use = 1'b1; cycle();
    rsv_dest = 2'd3; cycle();
    src1_use = 1'b0;
    rst = 1'b1; cycle(); rst = 1'b0; cycle();

    // Reset with two results buffered.
    drain_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rsv_valid = 1'b1; rsv_dest = 2'(i); res_valid = 1'b1; res_dest = 2'(i); res_data = 16'hA000 + 16'(i);
      cycle();
    end
    rsv_valid = 1'b0; res_valid = 1'b0; rst = 1'b1; cycle();
    rst = 1'b0; drain_en = 1'b1; repeat (4) cycle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 299) == 0);
      rsv_valid      = $urandom_range(0, 1);
      rsv_dest       = 2'($urandom_range(0, 3));
      res_valid      = $urandom_range(0, 1);
      res_dest       = 2'($urandom_range(0, 3));
      res_data       = 16'($urandom);
      drain_en       = ($urandom_range(0, 3) != 0);
      read_sources_1 = 2'($urandom_range(0, 3));
      read_sources_2 = 2'($urandom_range(0, 3));
      src1_use       = $urandom_range(0, 1);
      src2_use       = $urandom_range(0, 1);
      cycle();
    end

    idle_inputs(); drain_en = 1'b1;
    repeat (DEPTH + 3) cycle();
    chk("exp_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
